// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer
//   Rate-1/2 convolutional encoder with frame control, feeding a Viterbi decoder.
//   Each accepted information bit produces one 2-bit code symbol. After FRAME_LEN
//   data bits, K-1 zero tail bits are appended so every frame ends in state 0.
//
// Ports
//   CLOCK       in   rising-edge clock
//   Reset       in   synchronous, active-low reset
//   din         in   information bit
//   din_valid   in   din is valid
//   din_ready   out  block accepts din this cycle (combinational)
//   err_mask    in   [WD_CODE] XOR mask applied to loaded symbols (ERR_INJECT_EN only)
//   Code        out  [WD_CODE] registered code symbol
//   code_valid  out  Code holds a symbol not yet consumed
//   code_ready  in   downstream consumes Code this cycle
//   Active      out  sticky, set by the first loaded symbol with Code != 0
//   frame_done  out  one-cycle pulse when the last tail symbol is loaded
//
// Configuration
//   ERR_INJECT_EN  when defined, adds err_mask and XORs it into each loaded symbol.

module conv_encoder_framer #(
  parameter int unsigned K         = 9,
  parameter logic [K-1:0] G0       = 9'o561,
  parameter logic [K-1:0] G1       = 9'o753,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned WD_CODE   = 2
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               din,
  input  logic               din_valid,
  output logic               din_ready,
`ifdef ERR_INJECT_EN
  input  logic [WD_CODE-1:0] err_mask,
`endif
  output logic [WD_CODE-1:0] Code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               Active,
  output logic               frame_done
);

  localparam int unsigned CntW  = $clog2(FRAME_LEN + 1);
  localparam int unsigned TailW = $clog2(K);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_t;

  // State registers
  state_t             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [TailW-1:0]   r_tail_cnt;
  logic [K-2:0]       r_sr;
  logic [WD_CODE-1:0] r_code;
  logic               r_code_valid;
  logic               r_active;
  logic               r_frame_done;

  // Next-state / combinational signals
  state_t             w_state_nxt;
  logic [CntW-1:0]    w_cnt_nxt;
  logic [TailW-1:0]   w_tail_nxt;
  logic               w_slot_free;
  logic               w_hs;
  logic               w_enc;
  logic               w_bit;
  logic               w_done;
  logic [K-1:0]       w_taps;
  logic [WD_CODE-1:0] w_code_enc;
  logic [WD_CODE-1:0] w_code_load;

  // The output slot can take a new symbol when empty or being drained this cycle.
  assign w_slot_free = !r_code_valid || code_ready;

  // Reset gates din_ready so no handshake is seen while reset is asserted.
  assign din_ready = ((r_state == StIdle) || (r_state == StData)) && w_slot_free && Reset;
  assign w_hs      = din_valid && din_ready;

  // Bit k of the tap vector is the input delayed by k symbols.
  assign w_taps     = {r_sr, w_bit};
  assign w_code_enc = {^(G1 & w_taps), ^(G0 & w_taps)};

`ifdef ERR_INJECT_EN
  assign w_code_load = w_code_enc ^ err_mask;
`else
  assign w_code_load = w_code_enc;
`endif

  // Frame FSM: next state, counters and encode strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tail_nxt  = r_tail_cnt;
    w_enc       = 1'b0;
    w_bit       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_hs) begin
          w_enc     = 1'b1;
          w_bit     = din;
          w_cnt_nxt = CntW'(1);
          if (FRAME_LEN == 1) begin
            w_state_nxt = StTail;
            w_tail_nxt  = '0;
          end else begin
            w_state_nxt = StData;
          end
        end
      end
      StData: begin
        if (w_hs) begin
          w_enc     = 1'b1;
          w_bit     = din;
          w_cnt_nxt = r_cnt + CntW'(1);
          if (w_cnt_nxt == CntW'(FRAME_LEN)) begin
            w_state_nxt = StTail;
            w_tail_nxt  = '0;
          end
        end
      end
      StTail: begin
        // Tail symbols flush zeros through the register; they advance only when
        // the output slot can take them.
        if (w_slot_free) begin
          w_enc = 1'b1;
          w_bit = 1'b0;
          if (r_tail_cnt == TailW'(K - 2)) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_tail_nxt  = '0;
            w_state_nxt = StIdle;
          end else begin
            w_tail_nxt = r_tail_cnt + TailW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
        w_tail_nxt  = '0;
      end
    endcase
  end

  // State register, shift register and output register
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_tail_cnt   <= '0;
      r_sr         <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_active     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tail_cnt   <= w_tail_nxt;
      r_frame_done <= w_done;
      if (w_enc) begin
        // A new symbol overwrites the slot even if it is being consumed now.
        r_sr         <= {r_sr[K-3:0], w_bit};
        r_code       <= w_code_load;
        r_code_valid <= 1'b1;
        if (|w_code_load) begin
          r_active <= 1'b1;
        end
      end else if (code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

  assign Code       = r_code;
  assign code_valid = r_code_valid;
  assign Active     = r_active;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer
//   Directed bench for conv_encoder_framer with FRAME_LEN=4, K=9, G0=561, G1=753 (octal).
//   Expected symbols for din=1,0,1,1 plus eight zero tail bits were derived by hand
//   from the generator taps (G0 taps delays 0,4,5,6,8; G1 taps delays 0,1,3,5,6,7,8).

module tb_conv_encoder_framer;

  logic       CLOCK;
  logic       Reset;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] Code;
  logic       code_valid;
  logic       code_ready;
  logic       Active;
  logic       frame_done;
`ifdef ERR_INJECT_EN
  logic [1:0] err_mask;
  logic [1:0] mask_first;
`endif

  int n_checks;
  int n_err;

  logic [1:0] exp_q [12];

  conv_encoder_framer #(
    .FRAME_LEN (4)
  ) dut (
    .CLOCK      (CLOCK),
    .Reset      (Reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
`ifdef ERR_INJECT_EN
    .err_mask   (err_mask),
`endif
    .Code       (Code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .Active     (Active),
    .frame_done (frame_done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Symbols for din=1,0,1,1 followed by eight tail zeros.
  task automatic load_std();
    exp_q[0]  = 2'b11; exp_q[1]  = 2'b10; exp_q[2]  = 2'b11; exp_q[3]  = 2'b11;
    exp_q[4]  = 2'b11; exp_q[5]  = 2'b01; exp_q[6]  = 2'b00; exp_q[7]  = 2'b00;
    exp_q[8]  = 2'b11; exp_q[9]  = 2'b01; exp_q[10] = 2'b01; exp_q[11] = 2'b11;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    Reset      = 1'b0;
    din_valid  = 1'b0;
    din        = 1'b0;
    code_ready = 1'b1;
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_code", Code, 2'b00);
    check("rst_active", Active, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_din_ready", din_ready, 1'b0);
    @(negedge CLOCK);
    Reset = 1'b1;
    #1;
    check("idle_din_ready", din_ready, 1'b1);
  endtask

  // Sends one 4-bit frame (bits[0] first) and checks every consumed symbol against exp_q.
  // code_ready is held low for stall_len cycles starting at cycle stall_at.
  task automatic run_frame(input logic [3:0] bits, input int stall_at, input int stall_len,
                           input logic exp_active);
    int   ptr;
    int   idx;
    int   cyc;
    int   fd;
    int   nrdy;
    logic stalled;
    ptr  = 0;
    idx  = 0;
    cyc  = 0;
    fd   = 0;
    nrdy = 0;
    while (idx < 12 && cyc < 60) begin
      stalled    = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      din_valid  = (ptr < 4);
      din        = 1'b0;
      if (ptr < 4) din = bits[ptr];
      code_ready = !stalled;
`ifdef ERR_INJECT_EN
      err_mask = (ptr == 0) ? mask_first : 2'b00;
`endif
      #1;
      if (stalled) begin
        check("stall_code", Code, exp_q[idx]);
        check("stall_valid", code_valid, 1'b1);
        check("stall_din_ready", din_ready, 1'b0);
      end
      if (frame_done) begin
        fd++;
        check("done_code", Code, exp_q[11]);
        check("done_idx", idx, 11);
        check("done_active", Active, exp_active);
      end
      if (code_valid && code_ready) begin
        check("sym", Code, exp_q[idx]);
        if (idx == 0) check("active_first", Active, exp_active);
        idx++;
      end
      if (din_valid && din_ready) ptr++;
      if (code_ready && !din_ready) nrdy++;
      @(posedge CLOCK);
      @(negedge CLOCK);
      cyc++;
    end
    check("frame_symbols", idx, 12);
    check("frame_done_cnt", fd, 1);
    check("tail_ready_low", nrdy, 8);
    #1;
    check("end_code_valid", code_valid, 1'b0);
    check("end_din_ready", din_ready, 1'b1);
    check("end_sr_zero", dut.r_sr, 8'h00);
    check("end_active", Active, exp_active);
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    Reset      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    code_ready = 1'b1;
`ifdef ERR_INJECT_EN
    err_mask   = 2'b00;
    mask_first = 2'b00;
`endif

    // All-zero frame: symbols flow but every Code is 00 and Active stays low.
    do_reset();
    for (int i = 0; i < 12; i++) exp_q[i] = 2'b00;
    run_frame(4'b0000, 100, 0, 1'b0);

    // din=1,0,1,1 back-to-back; Active rises with the first symbol (11).
    load_std();
    run_frame(4'b1101, 100, 0, 1'b1);

    // Same frame with a 5-cycle back-pressure stall mid-frame.
    run_frame(4'b1101, 2, 5, 1'b1);

    // Reset asserted while in the tail aborts the frame.
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din       = (i == 1) ? 1'b0 : 1'b1;
      @(posedge CLOCK);
      @(negedge CLOCK);
    end
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK);
      @(negedge CLOCK);
    end
    #1;
    check("tail_din_ready", din_ready, 1'b0);
    check("tail_code_valid", code_valid, 1'b1);
    Reset = 1'b0;
    @(posedge CLOCK);
    #1;
    check("abort_code_valid", code_valid, 1'b0);
    check("abort_active", Active, 1'b0);
    check("abort_frame_done", frame_done, 1'b0);
    @(negedge CLOCK);
    Reset = 1'b1;
    run_frame(4'b1101, 100, 0, 1'b1);

`ifdef ERR_INJECT_EN
    // Mask 01 on the first symbol flips 11 to 10; later symbols are clean.
    do_reset();
    load_std();
    exp_q[0]   = 2'b10;
    mask_first = 2'b01;
    run_frame(4'b1101, 100, 0, 1'b1);
    mask_first = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Transmit-side counterpart of the Viterbi decoder: rate-1/2 convolutional encoder with frame control.
- Accepts information bits over a valid/ready handshake and emits one 2-bit code symbol per accepted bit.
- After FRAME_LEN data bits, appends K-1 zero tail bits so every frame ends in encoder state 0, the state the decoder's traceback expects.
- Drives the decoder-side Code bus and the Active flag.

Parameters:
- K, 9, constraint length; shift register is K-1 bits.
- G0, 9'o561, generator polynomial for Code[0]; bit k taps the input delayed k symbols.
- G1, 9'o753, generator polynomial for Code[1].
- FRAME_LEN, 64, data bits per frame; legal range 1..65535.
- WD_CODE, 2, code symbol width; fixed at 2.

Ports:
- CLOCK  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous, active-low.
- din  in  1  information bit.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- Code  out  WD_CODE  encoded symbol, registered.
- code_valid  out  1  Code holds a symbol not yet consumed.
- code_ready  in  1  downstream consumes Code this cycle.
- Active  out  1  sticky; set by the first emitted symbol with Code != 0.
- frame_done  out  1  one-cycle pulse when the last tail symbol is loaded.

Behaviour:
- Reset (Reset==0 at a CLOCK edge): state=IDLE, sr=0, bit counter=0, Code=2'b00, code_valid=0, Active=0, frame_done=0.
  - Reset mid-frame aborts the frame immediately and emits no tail.
- Output slot free: slot_free = !code_valid | code_ready.
- din_ready = (state==IDLE | state==DATA) & slot_free & Reset. It is combinational and does not depend on din_valid.
- Tap vector: t[K-1:0] = {sr[K-2:0], b}, where b is the bit being encoded.
  - Next Code[0] = ^(G0 & t); next Code[1] = ^(G1 & t).
  - sr <= {sr[K-3:0], b}.
- Encoding latency: one cycle. A symbol encoded at edge n appears on Code/code_valid after edge n.
- Output register:
  - If a new symbol is encoded, load it and set code_valid=1.
  - Else if code_ready, clear code_valid; Code holds its last value.
  - Else hold Code and code_valid unchanged.
- FSM:
  - IDLE: on din_valid & din_ready, encode b=din, counter=1, go DATA. If FRAME_LEN==1, go TAIL instead.
  - DATA: on handshake, encode b=din, counter++. On the handshake where counter reaches FRAME_LEN, go TAIL with tail counter=0.
  - TAIL: din_ready=0. Each cycle with slot_free, encode b=0 and increment the tail counter. On the (K-1)th tail symbol, pulse frame_done, clear the counters, go IDLE.
  - On entering IDLE after TAIL, sr==0 is guaranteed by construction.
- No bubbles: with code_ready held at 1 and din_valid held at 1, throughput is one symbol per cycle. Each frame emits exactly FRAME_LEN + K - 1 symbols.
- Back-pressure: code_ready=0 stalls the FSM, sr and the counters. No symbol is dropped or duplicated.
- Simultaneous events:
  - code_ready and a new encode in the same cycle: the new symbol replaces the consumed one and code_valid stays 1.
  - Reset has priority over all other events.
- Active: set when a symbol with Code != 0 is loaded; cleared only by reset.
- Counter width: $clog2(FRAME_LEN+1); the tail counter is $clog2(K) bits.

Optional Feature:
- Macro ERR_INJECT_EN.
- When defined:
  - Adds input err_mask[WD_CODE-1:0].
  - When a symbol is loaded, the stored Code is the encoded value XOR err_mask sampled in the same cycle.
  - Active evaluates the post-XOR value.
  - Use: channel-error stimulus for decoder error-correction tests.
- When undefined: no err_mask port, no XOR logic; Code is the pure encoder output.

Test Plan:
- Reset, then send din=1, then din=0, with code_ready=1 → Code sequence 2'b11, 2'b10. Active rises on the first symbol. din_ready=1 throughout.
- FRAME_LEN=4, din=1,0,1,1 back-to-back → 12 consecutive valid symbols; din_ready low for the 8 tail cycles; frame_done pulses once with the 12th load; block then returns to IDLE with sr==0.
- code_ready held 0 for 5 cycles mid-frame → Code and code_valid frozen, din_ready=0; on release the sequence resumes exactly, matching the no-stall reference run.
- Reset pulled low during TAIL → next edge: code_valid=0, Active=0, frame_done=0. A new frame starting with din=1 emits 2'b11 as its first symbol.
- All-zero frame → code_valid pulses but every Code=2'b00; Active stays 0 through frame_done.
- ERR_INJECT_EN defined, err_mask=2'b01 on the 1st symbol → first Code=2'b10 instead of 2'b11; symbols with err_mask=0 are unaffected.
